serial_pattern_generator: RTL
=============================

Name: serial_pattern_generator

Overview:
Serial bit-stream transmitter: the source side of our serial sequence detectors. Takes a parallel pattern, bit length and repeat count, then emits the pattern MSB-first, one bit per clock, on a 1-bit serial output. Used to drive detector inputs (e.g. the 1011 Mealy detector) and as a stimulus generator in sequence-detection subsystems. Start/busy/done handshake to the controlling logic.

Parameters:
WIDTH, 4, maximum pattern length in bits (>=2)
CNT_W, 4, width of repeat-count input
GAP, 0, idle cycles (o=0, valid=0) inserted between repetitions; 0 = back-to-back

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-low reset
start  input  1  request to begin a transfer, sampled only in IDLE
pattern  input  WIDTH  bits to send; pattern[len-1] sent first, pattern[0] last
len  input  $clog2(WIDTH)+1  number of pattern bits to send per repetition
repeat  input  CNT_W  number of repetitions
o  output  1  serial data bit
valid  output  1  o carries a pattern bit this cycle
busy  output  1  transfer in progress (SEND or GAP)
done  output  1  one-cycle pulse after the final bit

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst=0 at a rising edge resets). All outputs registered.
- Reset: state=IDLE, o=0, valid=0, busy=0, done=0, internal counters=0. Applies mid-transfer: the transfer is aborted at that edge with no done pulse.
- States: IDLE, SEND, GAP, DONE.
- IDLE: o=0, valid=0, busy=0. If start=1 and 1<=len<=WIDTH and repeat!=0, capture pattern/len/repeat into internal registers and go to SEND. Otherwise remain in IDLE; illegal requests (len=0, len>WIDTH, repeat=0) are silently ignored with no done pulse.
- Latency: start sampled at edge N -> first bit on o with valid=1 and busy=1 during the cycle after edge N.
- SEND: o=captured pattern[bit_idx], valid=1, busy=1. bit_idx starts at len-1 and decrements each cycle.
  - When bit_idx=0 and repetitions remain: go to GAP if GAP>0, else reload bit_idx=len-1 and stay in SEND. Back-to-back repetitions have no bubble.
  - When bit_idx=0 on the last repetition: go to DONE.
- GAP: o=0, valid=0, busy=1 for exactly GAP cycles, then SEND with bit_idx=len-1.
- DONE: o=0, valid=0, busy=0, done=1 for exactly one cycle, then IDLE. A new start is accepted in the IDLE cycle that follows, not in the DONE cycle.
- start while busy or in DONE: ignored. Inputs pattern, len and repeat are don't-care except at capture.
- Counting rules:
  - Total valid cycles = len*repeat.
  - Total busy cycles = len*repeat + GAP*(repeat-1).
  - repeat=2^CNT_W-1 must work, with no wrap of the repeat counter.
- o is always 0 when valid=0.

Test Plan:
- GAP=0, start with pattern=4'b1011, len=4, repeat=1 -> o=1,0,1,1 on the 4 cycles after the start edge with valid=1, busy=1; done=1 on the 5th cycle; then IDLE with all outputs 0.
- GAP=0, pattern=4'b1011, len=4, repeat=3 -> 12 consecutive valid cycles, o=101110111011; one done pulse. A connected 1011 detector must assert f on each completed occurrence of 1011, overlaps included.
- pattern=4'b0101, len=3, repeat=2, GAP=2 instance -> o/valid = 1,0,1 (valid), 0,0 (valid=0, busy=1), 1,0,1 (valid), then done.
- start pulsed again mid-transfer and during DONE -> ignored; the output stream is identical to the single-start case.
- len=0, len=5 (WIDTH=4), or repeat=0 with start=1 -> no valid, busy or done; stays IDLE.
- rst=0 asserted on the 3rd bit of a repeat=2 transfer -> the next edge gives o=0, valid=0, busy=0, done=0; no done pulse ever; a fresh start after rst=1 behaves normally.

Source files
------------

// File: rtl/serial_pattern_generator_if.sv
// Control and serial-stream bundle for serial_pattern_generator.
// "rpt" carries the repetition count (repeat is a reserved word).
interface serial_pattern_generator_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
);
   localparam int LW = $clog2(WIDTH) + 1;

   logic             start;
   logic [WIDTH-1:0] pattern;
   logic [LW-1:0]    len;
   logic [CNT_W-1:0] rpt;
   logic             o;
   logic             valid;
   logic             busy;
   logic             done;

   modport master (
      output start, pattern, len, rpt,
      input  o, valid, busy, done
   );

   modport slave (
      input  start, pattern, len, rpt,
      output o, valid, busy, done
   );
endinterface

// File: rtl/serial_pattern_generator.sv
// MSB-first serial pattern transmitter with repeat count and optional
// inter-repetition gap; start/busy/done handshake, all outputs registered.
module serial_pattern_generator #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4,
   parameter int GAP   = 0
) (
   input logic                      clk,
   input logic                      rst,
   serial_pattern_generator_if.slave bus
);
   localparam int LW = $clog2(WIDTH) + 1;
   localparam int IW = $clog2(WIDTH);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [LW-1:0]    LEN_MAX = LW'(WIDTH);
   localparam logic [IW-1:0]    IDX_ONE = IW'(1);
   localparam logic [CNT_W-1:0] REP_ONE = CNT_W'(1);
   localparam logic [GW-1:0]    GAP_ONE = GW'(1);
   localparam logic [GW-1:0]    GAP_M1  = GW'(GAP - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_GAP,
      S_DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] pat_q;
   logic [IW-1:0]    last_q;
   logic [IW-1:0]    idx_q;
   logic [CNT_W-1:0] rep_q;
   logic [GW-1:0]    gap_q;
   logic             o_q;
   logic             valid_q;
   logic             busy_q;
   logic             done_q;

   logic          legal;
   logic [IW-1:0] len_m1;
   logic [IW-1:0] nxt_idx;

   assign legal = bus.start
                & (bus.len != '0)
                & (bus.len <= LEN_MAX)
                & (bus.rpt != '0);

   assign len_m1  = IW'(bus.len - LW'(1));
   assign nxt_idx = idx_q - IDX_ONE;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= S_IDLE;
         pat_q   <= '0;
         last_q  <= '0;
         idx_q   <= '0;
         rep_q   <= '0;
         gap_q   <= '0;
         o_q     <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            S_IDLE: begin
               o_q     <= 1'b0;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               if (legal) begin
                  pat_q   <= bus.pattern;
                  last_q  <= len_m1;
                  idx_q   <= len_m1;
                  rep_q   <= bus.rpt;
                  o_q     <= bus.pattern[len_m1];
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state   <= S_SEND;
               end
            end
            S_SEND: begin
               if (idx_q != '0) begin
                  idx_q <= nxt_idx;
                  o_q   <= pat_q[nxt_idx];
               end else if (rep_q != REP_ONE) begin
                  // rep_q counts the repetition in flight, so it
                  // never wraps even at the all-ones request
                  rep_q <= rep_q - REP_ONE;
                  if (GAP > 0) begin
                     gap_q   <= GAP_M1;
                     o_q     <= 1'b0;
                     valid_q <= 1'b0;
                     state   <= S_GAP;
                  end else begin
                     idx_q <= last_q;
                     o_q   <= pat_q[last_q];
                  end
               end else begin
                  rep_q   <= '0;
                  o_q     <= 1'b0;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state   <= S_DONE;
               end
            end
            S_GAP: begin
               if (gap_q != '0) begin
                  gap_q <= gap_q - GAP_ONE;
               end else begin
                  idx_q   <= last_q;
                  o_q     <= pat_q[last_q];
                  valid_q <= 1'b1;
                  state   <= S_SEND;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.o     = o_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
endmodule
